// File: rtl/axil_mmio_bridge.sv
// AXI4-Lite slave that forwards single accesses to an array of MMIO slots.
// One transaction in flight; each slot access is bounded by a timeout.
module axil_mmio_bridge #(
    parameter int unsigned NUM_SLOTS      = 16,
    parameter int unsigned REG_ADDR_W     = 8,
    parameter int unsigned BASE_PAGE      = 16'h4600,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      aclk,
    input  logic                      arst_n,
    input  logic [31:0]               S_AXI_awaddr,
    input  logic [2:0]                S_AXI_awprot,
    input  logic                      S_AXI_awvalid,
    output logic                      S_AXI_awready,
    input  logic [31:0]               S_AXI_wdata,
    input  logic [3:0]                S_AXI_wstrb,
    input  logic                      S_AXI_wvalid,
    output logic                      S_AXI_wready,
    output logic [1:0]                S_AXI_bresp,
    output logic                      S_AXI_bvalid,
    input  logic                      S_AXI_bready,
    input  logic [31:0]               S_AXI_araddr,
    input  logic [2:0]                S_AXI_arprot,
    input  logic                      S_AXI_arvalid,
    output logic                      S_AXI_arready,
    output logic [31:0]               S_AXI_rdata,
    output logic [1:0]                S_AXI_rresp,
    output logic                      S_AXI_rvalid,
    input  logic                      S_AXI_rready,
    output logic [NUM_SLOTS-1:0]      slot_chip_select,
    output logic                      slot_read,
    output logic                      slot_write,
    output logic [REG_ADDR_W-1:0]     slot_reg_addr,
    output logic [31:0]               slot_wr_data,
    output logic [3:0]                slot_wr_strb,
    input  logic [NUM_SLOTS*32-1:0]   slot_rd_data,
    input  logic [NUM_SLOTS-1:0]      slot_wr_done,
    input  logic [NUM_SLOTS-1:0]      slot_rd_done,
    input  logic [NUM_SLOTS-1:0]      slot_slave_error,
    input  logic [NUM_SLOTS-1:0]      slot_decode_error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP
    } state_t;

    state_t                state_reg, state_next;
    logic [31:0]           addr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;
    logic [1:0]            resp_reg;
    logic [31:0]           rdata_reg;
    logic [TW-1:0]         timer_reg;
    logic                  last_wr_reg;

    logic [7:0]            slot_idx;
    logic [NUM_SLOTS-1:0]  slot_sel;
    logic [31:0]           sel_rdata;
    logic                  sel_done, sel_slverr, sel_decerr;
    logic                  timed_out, grant_wr, aw_hs, ar_hs, mapped_lat;
    logic                  unused_prot;

    assign unused_prot = ^{S_AXI_awprot, S_AXI_arprot};

    // Page must match exactly and slot index must fall inside the populated range.
    function automatic logic is_mapped(input logic [31:0] a);
        logic [31:0] page;
        logic [7:0]  idx;
        page = a >> (REG_ADDR_W + 8);
        idx  = a[REG_ADDR_W+7 -: 8];
        return (page == 32'(BASE_PAGE)) && ({1'b0, idx} < 9'(NUM_SLOTS));
    endfunction

    assign slot_idx   = addr_reg[REG_ADDR_W+7 -: 8];
    assign mapped_lat = is_mapped(addr_reg);

    generate
        for (genvar gi = 0; gi < int'(NUM_SLOTS); gi++) begin : g_sel
            assign slot_sel[gi] = (slot_idx == 8'(gi));
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_sel[i]) sel_rdata = slot_rd_data[i*32 +: 32];
        end
    end

    assign sel_done   = (state_reg == WR_ACCESS) ? |(slot_wr_done & slot_sel)
                                                 : |(slot_rd_done & slot_sel);
    assign sel_slverr = |(slot_slave_error & slot_sel);
    assign sel_decerr = |(slot_decode_error & slot_sel);
    assign timed_out  = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

    // Round-robin: on a tie (or with nothing pending) favour the channel not served last.
    always_comb begin
        if (S_AXI_awvalid && S_AXI_arvalid) grant_wr = !last_wr_reg;
        else if (S_AXI_awvalid)             grant_wr = 1'b1;
        else if (S_AXI_arvalid)             grant_wr = 1'b0;
        else                                grant_wr = !last_wr_reg;
    end

    assign aw_hs = (state_reg == IDLE) && grant_wr && S_AXI_awvalid;
    assign ar_hs = (state_reg == IDLE) && !grant_wr && S_AXI_arvalid;

    always_comb begin
        state_next       = state_reg;
        S_AXI_awready    = 1'b0;
        S_AXI_arready    = 1'b0;
        S_AXI_wready     = 1'b0;
        S_AXI_bvalid     = 1'b0;
        S_AXI_rvalid     = 1'b0;
        slot_write       = 1'b0;
        slot_read        = 1'b0;
        slot_chip_select = '0;
        case (state_reg)
            IDLE: begin
                S_AXI_awready = grant_wr;
                S_AXI_arready = !grant_wr;
                if (aw_hs)      state_next = WR_DATA;
                else if (ar_hs) state_next = is_mapped(S_AXI_araddr) ? RD_ACCESS : RD_RESP;
            end
            WR_DATA: begin
                S_AXI_wready = 1'b1;
                if (S_AXI_wvalid) begin
                    if (mapped_lat && (S_AXI_wstrb != 4'h0)) state_next = WR_ACCESS;
                    else                                     state_next = WR_RESP;
                end
            end
            WR_ACCESS: begin
                slot_write       = 1'b1;
                slot_chip_select = slot_sel;
                if (sel_done || timed_out) state_next = WR_RESP;
            end
            RD_ACCESS: begin
                slot_read        = 1'b1;
                slot_chip_select = slot_sel;
                if (sel_done || timed_out) state_next = RD_RESP;
            end
            WR_RESP: begin
                S_AXI_bvalid = 1'b1;
                if (S_AXI_bready) state_next = IDLE;
            end
            RD_RESP: begin
                S_AXI_rvalid = 1'b1;
                if (S_AXI_rready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            resp_reg    <= RESP_OKAY;
            rdata_reg   <= '0;
            timer_reg   <= '0;
            last_wr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (aw_hs) begin
                        addr_reg    <= S_AXI_awaddr;
                        last_wr_reg <= 1'b1;
                    end else if (ar_hs) begin
                        addr_reg    <= S_AXI_araddr;
                        last_wr_reg <= 1'b0;
                        rdata_reg   <= '0;
                        resp_reg    <= is_mapped(S_AXI_araddr) ? RESP_OKAY : RESP_DECERR;
                    end
                end
                WR_DATA: begin
                    if (S_AXI_wvalid) begin
                        wdata_reg <= S_AXI_wdata;
                        wstrb_reg <= S_AXI_wstrb;
                        resp_reg  <= mapped_lat ? RESP_OKAY : RESP_DECERR;
                    end
                end
                WR_ACCESS, RD_ACCESS: begin
                    if (sel_done) begin
                        resp_reg <= sel_slverr ? RESP_SLVERR :
                                    sel_decerr ? RESP_DECERR : RESP_OKAY;
                        if (state_reg == RD_ACCESS) rdata_reg <= sel_rdata;
                    end else if (timed_out) begin
                        resp_reg  <= RESP_SLVERR;
                        rdata_reg <= '0;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_AXI_bresp   = resp_reg;
    assign S_AXI_rresp   = resp_reg;
    assign S_AXI_rdata   = rdata_reg;
    assign slot_reg_addr = addr_reg[REG_ADDR_W-1:0];
    assign slot_wr_data  = wdata_reg;
    assign slot_wr_strb  = wstrb_reg;

endmodule

// File: tb/tb_axil_mmio_bridge.sv
// Directed bench for axil_mmio_bridge: a behavioural slot array answers accesses,
// a monitor scores every B/R response against a queue filled at issue time.
module tb_axil_mmio_bridge;

    localparam int NS = 16;

    logic              aclk = 1'b0;
    logic              arst_n = 1'b1;
    logic [31:0]       S_AXI_awaddr = '0;
    logic [2:0]        S_AXI_awprot = '0;
    logic              S_AXI_awvalid = 1'b0;
    logic              S_AXI_awready;
    logic [31:0]       S_AXI_wdata = '0;
    logic [3:0]        S_AXI_wstrb = '0;
    logic              S_AXI_wvalid = 1'b0;
    logic              S_AXI_wready;
    logic [1:0]        S_AXI_bresp;
    logic              S_AXI_bvalid;
    logic              S_AXI_bready = 1'b1;
    logic [31:0]       S_AXI_araddr = '0;
    logic [2:0]        S_AXI_arprot = '0;
    logic              S_AXI_arvalid = 1'b0;
    logic              S_AXI_arready;
    logic [31:0]       S_AXI_rdata;
    logic [1:0]        S_AXI_rresp;
    logic              S_AXI_rvalid;
    logic              S_AXI_rready = 1'b1;
    logic [NS-1:0]     slot_chip_select;
    logic              slot_read, slot_write;
    logic [7:0]        slot_reg_addr;
    logic [31:0]       slot_wr_data;
    logic [3:0]        slot_wr_strb;
    logic [NS*32-1:0]  slot_rd_data;
    logic [NS-1:0]     slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error;

    axil_mmio_bridge #(
        .NUM_SLOTS(NS), .REG_ADDR_W(8), .BASE_PAGE(16'h4600), .TIMEOUT_CYCLES(255)
    ) dut (
        .aclk(aclk), .arst_n(arst_n),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
        .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
        .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
        .slot_chip_select(slot_chip_select), .slot_read(slot_read), .slot_write(slot_write),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data), .slot_wr_strb(slot_wr_strb),
        .slot_rd_data(slot_rd_data), .slot_wr_done(slot_wr_done), .slot_rd_done(slot_rd_done),
        .slot_slave_error(slot_slave_error), .slot_decode_error(slot_decode_error)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];
    int vectors = 0;
    int miscompares = 0;

    // Slot behaviour knobs
    int          cfg_delay = 0;
    int          cfg_slot = 0;
    logic        cfg_never = 1'b0, cfg_slverr = 1'b0, cfg_decerr = 1'b0, cfg_noise = 1'b1;
    logic [31:0] cfg_rdata = '0;

    int acc_cnt = 0;
    int cyc = 0;
    int aw_hs_cyc = 0, b_first_cyc = 0;
    int strobe_cycles = 0, write_cycles = 0, cs_cycles = 0, b_cycles = 0;
    logic [NS-1:0] last_cs = '0;
    logic [7:0]    last_reg = '0;
    logic [31:0]   last_wdata = '0;
    logic [3:0]    last_strb = '0;
    logic          bvalid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (slot_write || slot_read) acc_cnt <= acc_cnt + 1;
        else                         acc_cnt <= 0;
    end

    always_comb begin
        logic          hit;
        logic [NS-1:0] noise;
        hit   = (slot_write || slot_read) && !cfg_never && (acc_cnt == cfg_delay);
        noise = cfg_noise ? ~slot_chip_select : '0;
        slot_wr_done      = ((hit && slot_write) ? slot_chip_select : '0) | noise;
        slot_rd_done      = ((hit && slot_read)  ? slot_chip_select : '0) | noise;
        slot_slave_error  = (cfg_slverr ? slot_chip_select : '0) | noise;
        slot_decode_error = (cfg_decerr ? slot_chip_select : '0) | noise;
        slot_rd_data = '0;
        for (int i = 0; i < NS; i++)
            slot_rd_data[i*32 +: 32] = (i == cfg_slot) ? cfg_rdata : (32'hBAD0_0000 + 32'(i));
    end

    // Response scoreboard and slot-side observation
    always @(negedge aclk) begin
        if (arst_n && S_AXI_bvalid && S_AXI_bready) begin
            if (bq.size() == 0) check("unexpected_bvalid", 32'(S_AXI_bvalid), 32'h0);
            else begin
                logic [1:0] e;
                e = bq.pop_front();
                $display("write resp: bresp=%0d expected=%0d", S_AXI_bresp, e);
                check("bresp", 32'(S_AXI_bresp), 32'(e));
            end
        end
        if (arst_n && S_AXI_rvalid && S_AXI_rready) begin
            if (rq.size() == 0) check("unexpected_rvalid", 32'(S_AXI_rvalid), 32'h0);
            else begin
                rexp_t e;
                e = rq.pop_front();
                $display("read resp: rresp=%0d rdata=0x%08h expected=%0d/0x%08h",
                         S_AXI_rresp, S_AXI_rdata, e.resp, e.data);
                check("rresp", 32'(S_AXI_rresp), 32'(e.resp));
                check("rdata", S_AXI_rdata, e.data);
            end
        end
        if (S_AXI_bvalid && !bvalid_prev) b_first_cyc = cyc;
        bvalid_prev = S_AXI_bvalid;
        if (S_AXI_bvalid) b_cycles++;
        if (slot_write || slot_read) begin
            strobe_cycles++;
            last_cs    = slot_chip_select;
            last_reg   = slot_reg_addr;
            last_wdata = slot_wr_data;
            last_strb  = slot_wr_strb;
        end
        if (slot_write) write_cycles++;
        if (slot_chip_select != '0) cs_cycles++;
    end

    task automatic wait_resp();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 1000) begin
            @(negedge aclk); #2; n++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            check("resp_timeout", 32'(bq.size() + rq.size()), 32'h0);
            bq.delete();
            rq.delete();
        end
        @(negedge aclk);
    endtask

    task automatic write_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        S_AXI_awaddr = a; S_AXI_awvalid = 1'b1;
        S_AXI_wdata = d; S_AXI_wstrb = s; S_AXI_wvalid = 1'b1;
        n = 0; #1;
        while (!S_AXI_awready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!S_AXI_awready) check("awready_wait", 32'(S_AXI_awready), 32'h1);
        aw_hs_cyc = cyc;
        @(negedge aclk); S_AXI_awvalid = 1'b0;
        n = 0; #1;
        while (!S_AXI_wready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!S_AXI_wready) check("wready_wait", 32'(S_AXI_wready), 32'h1);
        @(negedge aclk); S_AXI_wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp);
        bq.push_back(exp);
        write_issue(a, d, s);
        wait_resp();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] exp, input logic [31:0] expd);
        int n;
        rq.push_back('{resp: exp, data: expd});
        S_AXI_araddr = a; S_AXI_arvalid = 1'b1;
        n = 0; #1;
        while (!S_AXI_arready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!S_AXI_arready) check("arready_wait", 32'(S_AXI_arready), 32'h1);
        @(negedge aclk); S_AXI_arvalid = 1'b0;
        wait_resp();
    endtask

    task automatic slot_cfg(input int slot, input int delay, input logic never,
                            input logic se, input logic de, input logic [31:0] rd);
        cfg_slot = slot; cfg_delay = delay; cfg_never = never;
        cfg_slverr = se; cfg_decerr = de; cfg_rdata = rd;
    endtask

    initial begin
        int s0, w0, c0, b0, n, grants;
        logic [3:0] order;

        // Reset values, before and after the first clock edge
        #1 arst_n = 1'b0;
        #2;
        check("rst_awready", 32'(S_AXI_awready), 32'h1);
        check("rst_arready", 32'(S_AXI_arready), 32'h0);
        check("rst_valids", {29'h0, S_AXI_wready, S_AXI_bvalid, S_AXI_rvalid}, 32'h0);
        check("rst_rdata", S_AXI_rdata, 32'h0);
        check("rst_resp", {28'h0, S_AXI_bresp, S_AXI_rresp}, 32'h0);
        check("rst_slot", {15'h0, slot_chip_select, slot_read}, 32'h0);
        repeat (3) @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);

        // Mapped write, slot 3 completes in its third access cycle
        slot_cfg(3, 2, 1'b0, 1'b0, 1'b0, 32'h0);
        s0 = strobe_cycles;
        do_write(32'h4600_0304, 32'hDEAD_BEEF, 4'hF, 2'b00);
        check("wr_cs", 32'(last_cs), 32'h0008);
        check("wr_reg", 32'(last_reg), 32'h04);
        check("wr_data", last_wdata, 32'hDEAD_BEEF);
        check("wr_strb", 32'(last_strb), 32'hF);
        check("wr_access_len", 32'(strobe_cycles - s0), 32'd3);

        // Read with slave error still returns the slot data
        slot_cfg(5, 1, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        do_read(32'h4600_0510, 2'b10, 32'h1234_5678);
        check("rd_cs", 32'(last_cs), 32'h0020);
        check("rd_reg", 32'(last_reg), 32'h10);

        // Unmapped page and out-of-range slot
        slot_cfg(0, 0, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
        c0 = cs_cycles;
        do_read(32'h4700_0000, 2'b11, 32'h0);
        do_write(32'h4600_1400, 32'h0BAD_F00D, 4'hF, 2'b11);
        check("decerr_no_cs", 32'(cs_cycles - c0), 32'h0);

        // Slot-reported errors, slave error takes priority
        slot_cfg(1, 0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_write(32'h4600_0120, 32'h1111_2222, 4'h3, 2'b11);
        slot_cfg(1, 0, 1'b0, 1'b1, 1'b1, 32'h0);
        do_write(32'h4600_0124, 32'h3333_4444, 4'h1, 2'b10);

        // Empty strobe: OKAY without touching the slot
        slot_cfg(2, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        w0 = write_cycles;
        do_write(32'h4600_0200, 32'h7777_7777, 4'h0, 2'b00);
        check("strb0_no_write", 32'(write_cycles - w0), 32'h0);

        // Minimum write latency, done in the first access cycle
        do_write(32'h4600_0208, 32'hA5A5_5A5A, 4'hC, 2'b00);
        check("wr_latency", 32'(b_first_cyc - aw_hs_cyc), 32'd3);
        check("wr_strb_c", 32'(last_strb), 32'hC);

        // A read leaves the arbiter favouring write on the next tie
        slot_cfg(2, 0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0002);
        do_read(32'h4600_0208, 2'b00, 32'hCAFE_0002);

        // Both address channels held valid: grants must alternate
        S_AXI_awaddr = 32'h4600_020C; S_AXI_awvalid = 1'b1;
        S_AXI_wdata = 32'h0000_1234; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
        S_AXI_araddr = 32'h4600_0210; S_AXI_arvalid = 1'b1;
        grants = 0; order = '0; n = 0;
        while (grants < 4 && n < 200) begin
            #1;
            if (S_AXI_awready) begin
                order = {order[2:0], 1'b1}; grants++; bq.push_back(2'b00);
            end else if (S_AXI_arready) begin
                order = {order[2:0], 1'b0}; grants++;
                rq.push_back('{resp: 2'b00, data: 32'hCAFE_0002});
            end
            @(negedge aclk); n++;
        end
        S_AXI_awvalid = 1'b0; S_AXI_arvalid = 1'b0;
        $display("arbitration: order=%b after %0d grants", order, grants);
        check("arb_order", 32'(order), 32'hA);
        wait_resp();
        S_AXI_wvalid = 1'b0;

        // Silent slot: both directions time out after 255 access cycles
        slot_cfg(7, 0, 1'b1, 1'b0, 1'b0, 32'h8888_9999);
        s0 = strobe_cycles;
        do_write(32'h4600_0700, 32'hFFFF_0000, 4'hF, 2'b10);
        check("wr_timeout_len", 32'(strobe_cycles - s0), 32'd255);
        s0 = strobe_cycles;
        do_read(32'h4600_0704, 2'b10, 32'h0);
        check("rd_timeout_len", 32'(strobe_cycles - s0), 32'd255);

        // Reset during a slot write abandons it
        slot_cfg(4, 0, 1'b1, 1'b0, 1'b0, 32'h0);
        b0 = b_cycles;
        write_issue(32'h4600_0400, 32'h0101_0101, 4'hF);
        n = 0;
        while (!slot_write && n < 20) begin @(negedge aclk); #1; n++; end
        check("rst_mid_in_access", 32'(slot_write), 32'h1);
        @(negedge aclk); #2;
        arst_n = 1'b0;
        #1;
        check("rst_mid_strobe", {15'h0, slot_chip_select, slot_write}, 32'h0);
        check("rst_mid_awready", 32'(S_AXI_awready), 32'h1);
        @(negedge aclk); @(negedge aclk);
        arst_n = 1'b1;
        repeat (10) @(negedge aclk);
        check("rst_mid_no_bvalid", 32'(b_cycles - b0), 32'h0);

        // Normal traffic resumes
        slot_cfg(3, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_write(32'h4600_0314, 32'h600D_600D, 4'hF, 2'b00);
        check("post_rst_cs", 32'(last_cs), 32'h0008);
        check("post_rst_reg", 32'(last_reg), 32'h14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_mmio_bridge.md
AXIL_MMIO_BRIDGE -- requirements
Module: axil_mmio_bridge

Interface
REQ-001 Parameter NUM_SLOTS, default 16, number of MMIO slots (1..256).
REQ-002 Parameter REG_ADDR_W, default 8, slot register address width.
REQ-003 Parameter BASE_PAGE, default 16'h4600, required value of address bits [31:REG_ADDR_W+8].
REQ-004 Parameter TIMEOUT_CYCLES, default 255, max cycles a slot access may take.
REQ-005 One clock, aclk; reset arst_n, asynchronous, active-low.
REQ-006 aclk  in  1  clock; arst_n  in  1  async active-low reset.
REQ-007 S_AXI_aw{addr 32, prot 3, valid 1} in; S_AXI_awready out 1; AXI4-Lite write address.
REQ-008 S_AXI_w{data 32, strb 4, valid 1} in; S_AXI_wready out 1; write data.
REQ-009 S_AXI_bresp out 2, S_AXI_bvalid out 1, S_AXI_bready in 1; write response.
REQ-010 S_AXI_ar{addr 32, prot 3, valid 1} in; S_AXI_arready out 1; read address.
REQ-011 S_AXI_rdata out 32, S_AXI_rresp out 2, S_AXI_rvalid out 1, S_AXI_rready in 1; read data.
REQ-012 slot_chip_select  out  NUM_SLOTS  one-hot selected slot.
REQ-013 slot_read, slot_write  out  1 each  access strobes.
REQ-014 slot_reg_addr  out  REG_ADDR_W; slot_wr_data  out  32; slot_wr_strb  out  4.
REQ-015 slot_rd_data  in  NUM_SLOTS x 32; slot_wr_done, slot_rd_done, slot_slave_error, slot_decode_error  in  NUM_SLOTS each.

Function
REQ-016 Address split: reg = addr[REG_ADDR_W-1:0]; slot index = addr[REG_ADDR_W+7:REG_ADDR_W]; page = addr[31:REG_ADDR_W+8].
REQ-017 Transaction is mapped iff page == BASE_PAGE and slot index < NUM_SLOTS; otherwise unmapped.
REQ-018 FSM states: IDLE, WR_DATA, WR_ACCESS, WR_RESP, RD_ACCESS, RD_RESP; one transaction outstanding at a time.
REQ-019 IDLE: exactly one of awready/arready high per cycle, the granted channel; other low.
REQ-020 Arbitration: if only one of awvalid/arvalid high, grant it; if both, grant the channel not granted last (round-robin); after reset, write wins first tie.
REQ-021 AW handshake: latch address -> WR_DATA next cycle; AR handshake: latch address -> RD_ACCESS if mapped, else RD_RESP with DECERR.
REQ-022 WR_DATA: wready=1; on W handshake latch wdata/wstrb -> WR_ACCESS if mapped and wstrb!=0; -> WR_RESP OKAY if mapped and wstrb==0 (no slot access); -> WR_RESP DECERR if unmapped.
REQ-023 WR_ACCESS/RD_ACCESS: chip_select bit of slot high, slot_write/slot_read high, reg_addr/wr_data/wr_strb driven from latched values, stable for whole state.
REQ-024 Access ends in cycle selected slot's done bit is 1: response captured (slave_error -> SLVERR, else decode_error -> DECERR, else OKAY; read data captured) -> *_RESP next cycle; strobes and chip_select low from that cycle.
REQ-025 Timeout: counter cleared on access entry, increments each access cycle; done absent after TIMEOUT_CYCLES cycles -> *_RESP with SLVERR, rdata 0.
REQ-026 Done bits of non-selected slots ignored.
REQ-027 WR_RESP: bvalid=1, bresp from register, stable until bready; -> IDLE on handshake.
REQ-028 RD_RESP: rvalid=1, rdata/rresp from registers, stable until rready; -> IDLE on handshake; rdata 0 for DECERR/timeout.
REQ-029 Handshake to next state latency: one cycle; minimum mapped write AW->bvalid 3 cycles with done in first access cycle.
REQ-030 prot accepted and ignored.

Reset
REQ-031 arst_n low: state IDLE, all registered addr/data/resp/timeout/arbiter state cleared, asynchronously.
REQ-032 During and after reset until first clock: all AXI valid/ready outputs 0 except IDLE awready=1 (tie default), slot strobes/chip_select 0, rdata 0, resp 0.
REQ-033 Reset mid-transaction abandons it: no bvalid/rvalid generated, slot strobes drop immediately.

Verification
REQ-034 Write 0x4600_0304 data 0xDEADBEEF strb 0xF, slot3 wr_done 2 cycles later -> chip_select=0x0008, reg_addr=0x04, bresp OKAY.
REQ-035 Read 0x4600_0510, slot5 rd_done with rd_data 0x12345678 and slave_error=1 -> rdata 0x12345678, rresp SLVERR.
REQ-036 Read 0x4700_0000 and write 0x4600_1400 with NUM_SLOTS=16 -> DECERR, rdata 0, no chip_select ever asserted.
REQ-037 awvalid and arvalid held high together for 4 transactions -> grants alternate W,R,W,R.
REQ-038 Slot never asserts done, TIMEOUT_CYCLES=255 -> SLVERR response after 255 access cycles; write with wstrb=0 -> OKAY, no slot_write.
REQ-039 Reset asserted in WR_ACCESS -> strobes 0 immediately, no bvalid, next transaction completes normally.
